// File: rtl/pcpu_alu_pkg.sv
// pcpu_alu_pkg -- shared types for the PCPU execute stage.
//   alu_op_t    : 4-bit op codes presented on pcpu_alu_exec.in_op
//   mul_state_t : iterative-multiplier sequencing states
//   FLAG_*      : bit positions of zf/cf/nf inside the packed flag register
package pcpu_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDC = 4'h1,
        OP_SUB  = 4'h2,
        OP_SUBC = 4'h3,
        OP_CMP  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_SLL  = 4'h8,
        OP_SRL  = 4'h9,
        OP_SRA  = 4'ha,
        OP_LDIH = 4'hb,
        OP_MOV  = 4'hc,
        OP_MUL  = 4'hd
        // 4'he, 4'hf unassigned -> illegal
    } alu_op_t;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } mul_state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_W = 3;

endpackage

// File: rtl/pcpu_mul_iter.sv
// pcpu_mul_iter -- iterative shift-add multiplier, one partial product per
// enabled clock, DATA_W iterations per product.
// Ports:
//   clock, reset (sync, active-high), enable (0 = freeze)
//   start   : load a/b and begin (ignored while busy is expected by caller)
//   a, b    : operands (a = multiplicand, b = multiplier)
//   busy    : an iteration will be performed on the next enabled edge
//   done    : the current edge performs the final iteration
//   product : full 2*DATA_W product as it will stand after this edge;
//             valid when done=1 so the caller can register it on that edge
module pcpu_mul_iter #(
    parameter int DATA_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] prod;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   addend;
    logic [DATA_W:0]     upper;
    logic [2*DATA_W-1:0] prod_next;

    // prod holds {partial sum, remaining multiplier bits}; each step adds the
    // multiplicand into the upper half when the current multiplier LSB is set
    // and shifts the whole register right by one.
    always_comb begin
        addend    = prod[0] ? mcand : '0;
        upper     = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, addend};
        prod_next = {upper, prod[DATA_W-1:1]};
    end

    assign done    = busy && (cnt == CNT_W'(DATA_W - 1));
    assign product = prod_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
        end else if (enable) begin
            if (start) begin
                busy  <= 1'b1;
                cnt   <= '0;
                mcand <= a;
                prod  <= {{DATA_W{1'b0}}, b};
            end else if (busy) begin
                prod <= prod_next;
                cnt  <= cnt + 1'b1;
                if (done)
                    busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pcpu_alu_exec.sv
// pcpu_alu_exec -- PCPU execute stage: op decode, adder/shifter, zf/cf/nf
// flag register and registered result outputs.
// Build option: define PCPU_ALU_MUL_EN to include the iterative multiplier
// (pcpu_mul_iter); otherwise MUL is treated as an illegal op and in_ready is 1.
// Ports:
//   clock, reset (sync, active-high), enable (0 = freeze all state)
//   in_valid/in_ready, in_op, in_a, in_b, in_dst : issue side
//   out_valid (1-cycle pulse per op), out_result, out_dst, out_wb : result
//   zf, cf, nf : flag register
module pcpu_alu_exec
    import pcpu_alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [REG_AW-1:0] in_dst,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_wb,
    output logic              zf,
    output logic              cf,
    output logic              nf
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int HALF = DATA_W / 2;

    logic [FLAG_W-1:0] flags;
    logic              accept;
    logic              single;

    // ---------------- combinational datapath ----------------
    logic [DATA_W:0]          sum;
    logic signed [DATA_W-1:0] sra;
    logic [SH_W-1:0]          shamt;
    logic [DATA_W-1:0]        res;
    logic                     res_wb;
    logic                     upd_c;
    logic                     upd_zn;
    logic                     c_new;

    assign shamt = in_b[SH_W-1:0];

    always_comb begin
        sum    = '0;
        sra    = $signed(in_a) >>> shamt;
        res    = '0;
        res_wb = 1'b0;
        upd_c  = 1'b0;
        upd_zn = 1'b0;
        c_new  = 1'b0;
        case (alu_op_t'(in_op))
            OP_ADD, OP_ADDC: begin
                sum    = {1'b0, in_a} + {1'b0, in_b}
                       + {{DATA_W{1'b0}}, (in_op == OP_ADDC) & flags[FLAG_C]};
                res    = sum[DATA_W-1:0];
                c_new  = sum[DATA_W];
                res_wb = 1'b1;
                upd_c  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                // bit DATA_W of the wrapped difference is the borrow
                sum    = {1'b0, in_a} - {1'b0, in_b}
                       - {{DATA_W{1'b0}}, (in_op == OP_SUBC) & flags[FLAG_C]};
                res    = sum[DATA_W-1:0];
                c_new  = sum[DATA_W];
                res_wb = (in_op != OP_CMP);
                upd_c  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_LDIH: begin
                sum    = {1'b0, in_a} + {1'b0, in_b << HALF};
                res    = sum[DATA_W-1:0];
                c_new  = sum[DATA_W];
                res_wb = 1'b1;
                upd_c  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_AND: begin res = in_a & in_b;   res_wb = 1'b1; upd_zn = 1'b1; end
            OP_OR:  begin res = in_a | in_b;   res_wb = 1'b1; upd_zn = 1'b1; end
            OP_XOR: begin res = in_a ^ in_b;   res_wb = 1'b1; upd_zn = 1'b1; end
            OP_SLL: begin res = in_a << shamt; res_wb = 1'b1; upd_zn = 1'b1; end
            OP_SRL: begin res = in_a >> shamt; res_wb = 1'b1; upd_zn = 1'b1; end
            OP_SRA: begin res = sra;           res_wb = 1'b1; upd_zn = 1'b1; end
            OP_MOV: begin res = in_b;          res_wb = 1'b1; upd_zn = 1'b1; end
            // MUL (when built without the multiplier) and unassigned codes:
            // pulse out_valid with a zero, non-written result, flags untouched.
            default: ;
        endcase
    end

    assign accept = in_valid && in_ready && enable;

`ifdef PCPU_ALU_MUL_EN
    // ---------------- multiplier sequencing ----------------
    mul_state_t          state_q;
    mul_state_t          state_d;
    logic                mul_start;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic [REG_AW-1:0]   mul_dst;

    assign mul_start = accept && (in_op == OP_MUL);
    assign single    = accept && (in_op != OP_MUL);
    assign in_ready  = (state_q == S_IDLE) && !mul_busy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (mul_start) state_d = S_MUL_RUN;
            S_MUL_RUN: if (mul_done)  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            mul_dst <= '0;
        end else if (enable) begin
            state_q <= state_d;
            if (mul_start)
                mul_dst <= in_dst;
        end
    end

    pcpu_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign single   = accept;
    assign in_ready = 1'b1;
`endif

    // ---------------- result and flag registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_dst    <= '0;
            out_wb     <= 1'b0;
            flags      <= '0;
        end else if (enable) begin
            out_valid <= 1'b0;
            if (single) begin
                out_valid  <= 1'b1;
                out_result <= res;
                out_dst    <= in_dst;
                out_wb     <= res_wb;
                if (upd_zn) begin
                    flags[FLAG_Z] <= (res == '0);
                    flags[FLAG_N] <= res[DATA_W-1];
                end
                if (upd_c)
                    flags[FLAG_C] <= c_new;
            end
`ifdef PCPU_ALU_MUL_EN
            else if (mul_done) begin
                out_valid     <= 1'b1;
                out_result    <= mul_product[DATA_W-1:0];
                out_dst       <= mul_dst;
                out_wb        <= 1'b1;
                flags[FLAG_Z] <= (mul_product[DATA_W-1:0] == '0);
                flags[FLAG_N] <= mul_product[DATA_W-1];
                flags[FLAG_C] <= (mul_product[2*DATA_W-1:DATA_W] != '0);
            end
`endif
        end
    end

    assign zf = flags[FLAG_Z];
    assign cf = flags[FLAG_C];
    assign nf = flags[FLAG_N];

endmodule

// File: tb/tb_pcpu_alu_exec.sv
// tb_pcpu_alu_exec -- directed, table-driven bench for pcpu_alu_exec
// (DATA_W=16). Multiplier sequences are exercised when PCPU_ALU_MUL_EN is
// defined; otherwise MUL is checked as an illegal op.
module tb_pcpu_alu_exec;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset, enable, in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [DW-1:0] in_a, in_b;
    logic [AW-1:0] in_dst;
    logic          out_valid, out_wb, zf, cf, nf;
    logic [DW-1:0] out_result;
    logic [AW-1:0] out_dst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcpu_alu_exec #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clock(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_dst(in_dst),
        .out_valid(out_valid), .out_result(out_result), .out_dst(out_dst),
        .out_wb(out_wb), .zf(zf), .cf(cf), .nf(nf)
    );

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] dst;
        logic [DW-1:0] res;
        logic          wb;
        logic          z;
        logic          c;
        logic          n;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [DW-1:0] r, input logic [AW-1:0] d,
                           input logic w, input logic z, input logic c, input logic n);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, 32'(out_result), 32'(r));
        chk({tag, ".dst"}, 32'(out_dst), 32'(d));
        chk({tag, ".wb"}, 32'(out_wb), 32'(w));
        chk({tag, ".flags"}, {29'd0, z, c, n}, {29'd0, zf, cf, nf} == {z, c, n} ? {29'd0, z, c, n} : {29'd0, zf, cf, nf} ^ 32'h8);
    endtask

    task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] d);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dst = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".out_result"}, 32'(out_result), 32'd0);
        chk({tag, ".out_dst"}, 32'(out_dst), 32'd0);
        chk({tag, ".out_wb"}, 32'(out_wb), 32'd0);
        chk({tag, ".flags"}, {29'd0, zf, cf, nf}, 32'd0);
    endtask

`ifdef PCPU_ALU_MUL_EN
    // Issue a MUL; returns the number of edges after the accept edge until
    // out_valid is seen (0 if never seen within the budget).
    task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] d,
                           input int stall_at, input int stall_len, output int lat);
        int edges;
        @(negedge clk);
        drive(4'hd, a, b, d);
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        edges = 0;
        for (int k = 0; k < 60 && lat == 0; k++) begin
            if (k == stall_at) enable = 1'b0;
            if (k == stall_at + stall_len) enable = 1'b1;
            @(posedge clk); #1;
            edges++;
            if (out_valid) lat = edges;
            @(negedge clk);
        end
        enable = 1'b1;
    endtask
`endif

    initial begin
        int lat;
        int low_cnt;
        int early;
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_dst = '0;

        //        op     a        b        dst   res      wb    z     c     n
        vecs.push_back('{4'h0, 16'h3c00, 16'h3cac, 3'd1, 16'h78ac, 1'b1, 1'b0, 1'b0, 1'b0}); // ADD
        vecs.push_back('{4'h2, 16'h3c00, 16'h3c00, 3'd2, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}); // SUB
        vecs.push_back('{4'h4, 16'h3c00, 16'h3cac, 3'd3, 16'hff54, 1'b0, 1'b0, 1'b1, 1'b1}); // CMP
        vecs.push_back('{4'h1, 16'h00ab, 16'h3c00, 3'd4, 16'h3cac, 1'b1, 1'b0, 1'b0, 1'b0}); // ADDC cin=1
        vecs.push_back('{4'h4, 16'h3c00, 16'h3cac, 3'd3, 16'hff54, 1'b0, 1'b0, 1'b1, 1'b1}); // CMP
        vecs.push_back('{4'h3, 16'h3c00, 16'h3cac, 3'd5, 16'hff53, 1'b1, 1'b0, 1'b1, 1'b1}); // SUBC bin=1
        vecs.push_back('{4'h2, 16'h0000, 16'h00ff, 3'd6, 16'hff01, 1'b1, 1'b0, 1'b1, 1'b1}); // SUB
        vecs.push_back('{4'h5, 16'hffff, 16'h0f0f, 3'd7, 16'h0f0f, 1'b1, 1'b0, 1'b1, 1'b0}); // AND cf held
        vecs.push_back('{4'hb, 16'hcccc, 16'h00fc, 3'd0, 16'hc8cc, 1'b1, 1'b0, 1'b1, 1'b1}); // LDIH
        vecs.push_back('{4'h6, 16'h00f0, 16'h0f00, 3'd1, 16'h0ff0, 1'b1, 1'b0, 1'b1, 1'b0}); // OR
        vecs.push_back('{4'h7, 16'ha5a5, 16'ha5a5, 3'd2, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}); // XOR
        vecs.push_back('{4'h8, 16'h0001, 16'h00ff, 3'd3, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1}); // SLL by 15
        vecs.push_back('{4'h9, 16'h8000, 16'h0014, 3'd4, 16'h0800, 1'b1, 1'b0, 1'b1, 1'b0}); // SRL by 4
        vecs.push_back('{4'ha, 16'h8000, 16'h0004, 3'd5, 16'hf800, 1'b1, 1'b0, 1'b1, 1'b1}); // SRA by 4
        vecs.push_back('{4'hc, 16'h1234, 16'h0000, 3'd6, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}); // MOV
        vecs.push_back('{4'h0, 16'hffff, 16'h0001, 3'd7, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}); // ADD carry
        vecs.push_back('{4'he, 16'h1234, 16'h5678, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0}); // illegal
        vecs.push_back('{4'h1, 16'h0001, 16'h0001, 3'd2, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0}); // ADDC cin=1
        vecs.push_back('{4'h3, 16'h0005, 16'h0003, 3'd3, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0}); // SUBC bin=0
`ifndef PCPU_ALU_MUL_EN
        vecs.push_back('{4'hd, 16'h0100, 16'h0100, 3'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}); // MUL illegal
`endif
        vecs.push_back('{4'hf, 16'hffff, 16'hffff, 3'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}); // illegal

        do_reset();
        chk_reset_state("reset");

        // back-to-back table ops
        foreach (vecs[i]) begin
            @(negedge clk);
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst);
            @(posedge clk); #1;
            chk_out($sformatf("v%0d", i), vecs[i].res, vecs[i].dst, vecs[i].wb,
                    vecs[i].z, vecs[i].c, vecs[i].n);
        end

        // enable=0 freezes everything, including a high out_valid
        @(negedge clk);
        drive(4'h0, 16'h0001, 16'h0001, 3'd6);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("freeze.valid", 32'(out_valid), 32'd1);
        chk("freeze.result", 32'(out_result), 32'h0000);
        chk("freeze.dst", 32'(out_dst), 32'd5);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        chk_out("unfreeze", 16'h0002, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pulse.drop", 32'(out_valid), 32'd0);

`ifdef PCPU_ALU_MUL_EN
        // MUL 0100*0100 with a second op held valid the whole time
        @(negedge clk);
        drive(4'hd, 16'h0100, 16'h0100, 3'd6);
        @(posedge clk); #1;
        @(negedge clk);
        drive(4'h0, 16'h0002, 16'h0003, 3'd7);
        low_cnt = 0; early = 0; lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (!in_ready) low_cnt++;
            @(posedge clk); #1;
            if (out_valid) lat = k;
            @(negedge clk);
        end
        chk("mul1.in_ready_low", 32'(low_cnt), 32'd16);
        chk("mul1.latency", 32'(lat), 32'd16);
        chk_out("mul1", 16'h0000, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("mul1.ready_back", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk_out("mul1.next", 16'h0005, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mul1.pulse", 32'(out_valid), 32'd0);

        // 3-cycle enable stall mid-MUL; high half nonzero -> cf=1
        run_mul(16'h1234, 16'h0010, 3'd2, 4, 3, lat);
        chk("mul2.latency", 32'(lat), 32'd19);
        chk_out("mul2", 16'h2340, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);

        // reset during iteration 5 aborts the MUL
        @(negedge clk);
        drive(4'hd, 16'h00ff, 16'h00ff, 3'd3);
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("mulrst");
        @(negedge clk);
        reset = 1'b0;
        early = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (out_valid) early++;
        end
        chk("mulrst.no_valid", 32'(early), 32'd0);
        chk("mulrst.in_ready", 32'(in_ready), 32'd1);
`else
        // without the multiplier in_ready must never drop around a MUL
        @(negedge clk);
        drive(4'hd, 16'h0003, 16'h0005, 3'd4);
        low_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (!in_ready) low_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("nomul.ready", 32'(low_cnt), 32'd0);
        chk("nomul.wb", 32'(out_wb), 32'd0);
`endif

        // plain reset after activity
        do_reset();
        chk_reset_state("reset2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
